writeback_unit: RTL and testbench

- Producer side of the register-file write port.
- Takes completed results from two execution channels: the single-cycle ALU path and the multi-cycle load/store (mem) path.
- Arbitrates between them with valid/ready handshakes and drives the register file's wen/rd_addr/rd_value from registers.
- Suppresses writes to x0 and counts retired instructions.

---
 rtl/writeback_unit.sv | 83 ++++++++
 tb/tb_writeback_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Register-file write port producer: arbitrates ALU and mem results, registers
// the winning write, suppresses x0 writes and counts retired instructions.
module writeback_unit #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic              alu_we,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_value,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_value,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_rd_addr,
  output logic [XLEN-1:0]   rf_rd_value,
  output logic              retire_valid,
  output logic [CNT_W-1:0]  retire_count
);
  localparam int SW_RAW = $clog2(STARVE_LIMIT + 1);
  localparam int SW     = (SW_RAW < 2) ? 2 : SW_RAW;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   value;
  } wb_req_t;

  logic [SW-1:0] starve_cnt;
  logic          force_alu, alu_acc, mem_acc, accept;
  wb_req_t       alu_req, mem_req, win;

  assign alu_req = '{we: alu_we, rd: alu_rd, value: alu_value};
  assign mem_req = '{we: mem_we, rd: mem_rd, value: mem_value};

  // mem has priority unless the ALU has been refused STARVE_LIMIT cycles in a row
  assign force_alu = alu_valid && (starve_cnt >= SW'(STARVE_LIMIT));
  assign mem_ready = rst_n && !force_alu;
  assign alu_ready = rst_n && (!mem_valid || force_alu);

  // the ready equations make these mutually exclusive
  assign alu_acc = alu_valid && alu_ready;
  assign mem_acc = mem_valid && mem_ready;
  assign accept  = alu_acc || mem_acc;
  assign win     = alu_acc ? alu_req : mem_req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!alu_valid || alu_acc) begin
      starve_cnt <= '0;
    end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen       <= 1'b0;
      rf_rd_addr   <= '0;
      rf_rd_value  <= '0;
      retire_valid <= 1'b0;
      retire_count <= '0;
    end else begin
      retire_valid <= accept;
      if (accept) begin
        rf_wen       <= win.we && (win.rd != '0);
        rf_rd_addr   <= win.rd;
        rf_rd_value  <= win.value;
        retire_count <= retire_count + 1'b1;
      end else begin
        rf_wen <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: handshake, x0/store suppression, collision,
// starvation, throughput and mid-stream reset.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready, alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        mem_valid, mem_ready, mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_value;
  logic        rf_wen;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_value;
  logic        retire_valid;
  logic [31:0] retire_count;

  int total = 0;
  int bad   = 0;

  writeback_unit #(.XLEN(32), .REG_AW(5), .STARVE_LIMIT(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_we(alu_we),
    .alu_rd(alu_rd), .alu_value(alu_value),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_rd(mem_rd), .mem_value(mem_value),
    .rf_wen(rf_wen), .rf_rd_addr(rf_rd_addr), .rf_rd_value(rf_rd_value),
    .retire_valid(retire_valid), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_we = 0; alu_rd = 0; alu_value = 0;
    mem_valid = 0; mem_we = 0; mem_rd = 0; mem_value = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    cyc(); cyc();
    chk("rst_wen", rf_wen, 0);
    chk("rst_addr", rf_rd_addr, 0);
    chk("rst_val", rf_rd_value, 0);
    chk("rst_ret", retire_valid, 0);
    chk("rst_cnt", retire_count, 0);
    chk("rst_ardy", alu_ready, 0);
    chk("rst_mrdy", mem_ready, 0);

    // 1: single ALU result
    rst_n = 1;
    alu_valid = 1; alu_we = 1; alu_rd = 5; alu_value = 32'hAA;
    #1 chk("t1_ardy", alu_ready, 1);
    cyc(); idle();
    chk("t1_wen", rf_wen, 1);
    chk("t1_addr", rf_rd_addr, 5);
    chk("t1_val", rf_rd_value, 32'hAA);
    chk("t1_ret", retire_valid, 1);
    chk("t1_cnt", retire_count, 1);
    cyc();
    chk("t1_wen0", rf_wen, 0);
    chk("t1_ret0", retire_valid, 0);

    // 2: x0 write and store are suppressed but still retire
    alu_valid = 1; alu_we = 1; alu_rd = 0; alu_value = 32'h1234;
    cyc(); idle();
    chk("t2_x0_wen", rf_wen, 0);
    chk("t2_x0_addr", rf_rd_addr, 0);
    chk("t2_x0_val", rf_rd_value, 32'h1234);
    chk("t2_x0_ret", retire_valid, 1);
    mem_valid = 1; mem_we = 0; mem_rd = 7; mem_value = 32'h55;
    #1 chk("t2_mrdy", mem_ready, 1);
    cyc(); idle();
    chk("t2_st_wen", rf_wen, 0);
    chk("t2_st_addr", rf_rd_addr, 7);
    chk("t2_cnt", retire_count, 3);

    // 3: collision, mem first then ALU
    mem_valid = 1; mem_we = 1; mem_rd = 3; mem_value = 32'h11;
    alu_valid = 1; alu_we = 1; alu_rd = 4; alu_value = 32'h22;
    #1;
    chk("t3_mrdy", mem_ready, 1);
    chk("t3_ardy0", alu_ready, 0);
    cyc();
    mem_valid = 0;
    chk("t3_wen_a", rf_wen, 1);
    chk("t3_addr_a", rf_rd_addr, 3);
    chk("t3_val_a", rf_rd_value, 32'h11);
    #1 chk("t3_ardy1", alu_ready, 1);
    cyc(); idle();
    chk("t3_wen_b", rf_wen, 1);
    chk("t3_addr_b", rf_rd_addr, 4);
    chk("t3_val_b", rf_rd_value, 32'h22);
    chk("t3_cnt", retire_count, 5);

    // 4: starvation, ALU forced in on the 4th refused-free cycle
    for (int i = 0; i < 10; i++) begin
      mem_valid = 1; mem_we = 1; mem_rd = 5'(10 + i); mem_value = 32'(i);
      alu_valid = (i <= 3); alu_we = 1; alu_rd = 20; alu_value = 32'hBEEF;
      #1;
      chk("t4_ardy", alu_ready, (i == 3));
      chk("t4_mrdy", mem_ready, (i != 3));
      cyc();
      chk("t4_addr", rf_rd_addr, (i == 3) ? 20 : 10 + i);
      chk("t4_val", rf_rd_value, (i == 3) ? 32'hBEEF : i);
      chk("t4_wen", rf_wen, 1);
    end
    idle();
    chk("t4_cnt", retire_count, 15);

    // 5: throughput after a fresh reset
    rst_n = 0;
    cyc();
    rst_n = 1;
    for (int i = 1; i <= 8; i++) begin
      alu_valid = 1; alu_we = 1; alu_rd = 5'(i); alu_value = 32'h100 + 32'(i);
      cyc();
      chk("t5_wen", rf_wen, 1);
      chk("t5_addr", rf_rd_addr, i);
      chk("t5_val", rf_rd_value, 32'h100 + i);
      chk("t5_ret", retire_valid, 1);
    end
    chk("t5_cnt", retire_count, 8);

    // 6: reset lands in the same cycle as a would-be accept
    alu_valid = 1; alu_we = 1; alu_rd = 9; alu_value = 32'h99;
    mem_valid = 1; mem_we = 1; mem_rd = 6; mem_value = 32'h66;
    rst_n = 0;
    #1;
    chk("t6_ardy", alu_ready, 0);
    chk("t6_mrdy", mem_ready, 0);
    cyc();
    chk("t6_wen", rf_wen, 0);
    chk("t6_cnt", retire_count, 0);
    chk("t6_ret", retire_valid, 0);
    chk("t6_addr", rf_rd_addr, 0);
    chk("t6_ardy_h", alu_ready, 0);
    chk("t6_mrdy_h", mem_ready, 0);
    idle();
    rst_n = 1;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
